seg7_scan6: RTL

Downstream display stage for the six-digit BCD counters: it takes six 4-bit BCD digits and drives a multiplexed, common-anode, six-digit seven-segment display with active-low segment and digit-select lines. It captures a tear-free snapshot of the digits once per scan frame and applies optional leading-zero blanking. Illegal codes are shown as a dash, and the whole display blinks while the count is all zero.

---
 rtl/seg7_scan6.sv | 133 +++++++++++++
 1 files changed

// File: rtl/seg7_scan6.sv
// seg7_scan6: six-digit multiplexed common-anode seven-segment driver.
// Frame-synchronous digit snapshot, leading-zero blanking, dash for illegal
// BCD codes, and a whole-display blink while the captured count is all zero.
module seg7_scan6 #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEAD         = 500,
  parameter int unsigned BLINK_FRAMES = 83
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digits [5:0],
  input  logic [5:0] dp,
  input  logic       blank_lz,
  output logic [7:0] seg,
  output logic [5:0] sel
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD  = CW'(DEAD);
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [3:0]    snap [5:0];
  logic [FW-1:0] fcnt, fcnt_nxt;
  logic          phase, phase_nxt;
  logic          loaded;

  logic          cnt_wrap;
  logic          frame_end;
  logic          allz;
  logic          run;
  logic [5:0]    lz;
  logic [3:0]    cur;
  logic          blanked;
  logic [7:0]    seg_nxt;
  logic [5:0]    sel_nxt;

  // Active-low segment pattern g..a for one BCD code; 10..15 become a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h40;
      4'd1:    p = 7'h79;
      4'd2:    p = 7'h24;
      4'd3:    p = 7'h30;
      4'd4:    p = 7'h19;
      4'd5:    p = 7'h12;
      4'd6:    p = 7'h02;
      4'd7:    p = 7'h78;
      4'd8:    p = 7'h00;
      4'd9:    p = 7'h10;
      default: p = 7'h3F;
    endcase
    return p;
  endfunction

  // Next scan position, blink state and display value from pre-edge state.
  always_comb begin
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    fcnt_nxt  = fcnt;
    phase_nxt = phase;
    seg_nxt   = 8'hFF;
    sel_nxt   = 6'h3F;
    allz      = 1'b1;
    run       = 1'b1;
    lz        = '0;

    cnt_wrap  = (cnt == CNT_LAST);
    frame_end = cnt_wrap && (idx == 3'd5);

    cnt_nxt = cnt_wrap ? '0 : cnt + CW'(1);
    if (cnt_wrap) begin
      idx_nxt = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end

    // lz[i]: this digit and every more significant digit are zero
    for (int i = 5; i >= 0; i--) begin
      run   = run && (snap[i] == 4'd0);
      lz[i] = run;
    end
    allz = run;

    if (!allz) begin
      fcnt_nxt  = '0;
      phase_nxt = 1'b1;
    end else if (frame_end) begin
      if (fcnt == FCNT_LAST) begin
        fcnt_nxt  = '0;
        phase_nxt = ~phase;
      end else begin
        fcnt_nxt = fcnt + FW'(1);
      end
    end

    cur     = snap[idx];
    blanked = blank_lz && (idx != 3'd0) && lz[idx];

    if ((cnt >= CNT_DEAD) && phase && loaded) begin
      sel_nxt = ~(6'd1 << idx);
      seg_nxt = blanked ? 8'hFF : {~dp[idx], decode(cur)};
    end
  end

  // Scan, snapshot, blink and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      idx    <= 3'd0;
      fcnt   <= '0;
      phase  <= 1'b1;
      loaded <= 1'b0;
      seg    <= 8'hFF;
      sel    <= 6'h3F;
      for (int i = 0; i < 6; i++) snap[i] <= 4'd0;
    end else begin
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      fcnt   <= fcnt_nxt;
      phase  <= phase_nxt;
      loaded <= 1'b1;
      seg    <= seg_nxt;
      sel    <= sel_nxt;
      if (!loaded || frame_end) begin
        for (int i = 0; i < 6; i++) snap[i] <= digits[i];
      end
    end
  end

endmodule
